alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max cycles spent in T1 waiting for mem_ready before fault.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin one fetch/execute sequence; sampled only in IDLE.
REQ-005 mem_ready  input  1  memory data valid on Mdatain during T1.
REQ-006 ir  input  32  datapath IR contents; fields opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
REQ-007 Rin / Rout  output  16 each  one-hot register-file load / bus-drive enables R0..R15.
REQ-008 HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin  output  1 each  datapath load enables.
REQ-009 HIout, LOout, Zhighout, Zlowout, PCout, MDRout  output  1 each  bus-drive enables.
REQ-010 IncPC, Read  output  1 each  PC-increment ALU select; memory read strobe.
REQ-011 alu_sel  output  13  one-hot ALU op, bit0..12 = ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,MUL,DIV.
REQ-012 busy  output  1  high in T0..T6.
REQ-013 done  output  1  high for exactly one cycle (DONE state) after a successful instruction.
REQ-014 fault / fault_code  output  1 / 2  one-cycle fault pulse; code 01 = memory timeout, 10 = illegal opcode, held until next start.
REQ-015 instr_count  output  16  completed-instruction counter.

Function
REQ-016 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, FAULT; all control outputs Moore-decoded from state (plus ir in T3..T6).
REQ-017 IDLE: all controls 0; start=1 -> T0.
REQ-018 T0: PCout, MARin, IncPC, Zin; -> T1.
REQ-019 T1: Zlowout, PCin, Read, MDRin every T1 cycle; mem_ready=1 -> T2; wait counter increments otherwise.
REQ-020 Wait counter reaching MEM_TIMEOUT with mem_ready=0 -> FAULT, code 01.
REQ-021 T2: MDRout, IRin; -> T3 (ir valid from T3 onward).
REQ-022 Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010; any other -> FAULT code 10 from T3, no register/Y/Z enables asserted.
REQ-023 Three-operand ops: T3 Rout[Rb], Yin; T4 Rout[Rc], alu_sel op, Zin; T5 Zlowout, Rin[Ra]; -> DONE.
REQ-024 NEG/NOT: T3 Rout[Rb], Yin; T4 Rout[Rb], alu_sel op, Zin; T5 Zlowout, Rin[Ra]; -> DONE.
REQ-025 MUL/DIV: T3 Rout[Ra], Yin; T4 Rout[Rb], alu_sel op, Zin; T5 Zlowout, LOin; T6 Zhighout, HIin; -> DONE.
REQ-026 Exactly one bus driver asserted per cycle; Rin/Rout at most one bit set.
REQ-027 DONE: done=1, instr_count+1 (wraps 0xFFFF->0x0000), fault_code cleared; -> IDLE.
REQ-028 FAULT: fault=1 one cycle, instr_count unchanged; -> IDLE.
REQ-029 start outside IDLE ignored; start held high in IDLE after DONE/FAULT launches a new sequence immediately.
REQ-030 Latency with mem_ready=1: start edge -> done high 7 cycles later (three-operand/unary), 8 cycles (MUL/DIV); each mem_ready=0 cycle adds one.

Reset
REQ-031 clear=0 SHALL immediately force IDLE, all outputs 0, wait counter 0, instr_count 0, fault_code 00, regardless of current state.
REQ-032 First start is accepted on the first rising edge after clear deasserts.

Structure
REQ-033 Package alu_seq_pkg SHALL hold state encoding, opcode constants, alu_sel bit indices, fault codes.
REQ-034 One sub-module, reg_decode (4-bit field -> 16-bit one-hot with enable), used for Rin and Rout.

Verification
REQ-035 Reset, start, ir=0x292B0000 (AND R2,R5,R6), mem_ready=1 -> T3 Rout[5]+Yin, T4 Rout[6]+alu_sel AND+Zin, T5 Zlowout+Rin[2], done 7 cycles after start, instr_count=1.
REQ-036 ir=0x81880000 (DIV R3,R1) -> T3 Rout[3]+Yin, T4 Rout[1]+DIV+Zin, T5 Zlowout+LOin, T6 Zhighout+HIin, done at cycle 8.
REQ-037 mem_ready low 3 cycles in T1 -> T1 lasts 4 cycles, Read/MDRin high throughout, done at cycle 10.
REQ-038 mem_ready never asserted -> fault pulse, fault_code=01 after 15 T1 cycles, no IRin, instr_count unchanged.
REQ-039 ir=0x00000000 -> fault_code=10 in cycle after T3 decision, Rin/Yin/Zin never asserted in T3.
REQ-040 clear pulsed low during T4 of an ADD -> all outputs 0 same cycle, IDLE, instr_count=0; next start runs full sequence.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, opcodes, ALU select
// bit positions, fault codes and the opcode classifier.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_FAULT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int ALU_W    = 13;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_SHR  = 4;
  localparam int ALU_SHRA = 5;
  localparam int ALU_SHL  = 6;
  localparam int ALU_ROR  = 7;
  localparam int ALU_ROL  = 8;
  localparam int ALU_NEG  = 9;
  localparam int ALU_NOT  = 10;
  localparam int ALU_MUL  = 11;
  localparam int ALU_DIV  = 12;

  localparam logic [1:0] FC_NONE        = 2'b00;
  localparam logic [1:0] FC_MEM_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL     = 2'b10;

  typedef enum logic [1:0] {
    CLS_ILLEGAL, CLS_THREE, CLS_UNARY, CLS_MULDIV
  } op_class_t;

  typedef struct packed {
    op_class_t          cls;
    logic [ALU_W-1:0]   sel;
  } op_decode_t;

  // Illegal opcodes come back with an all-zero ALU select.
  function automatic op_decode_t decode_op(input logic [4:0] opcode);
    op_decode_t d;
    d.cls = CLS_ILLEGAL;
    d.sel = '0;
    case (opcode)
      OP_ADD:  begin d.cls = CLS_THREE;  d.sel[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin d.cls = CLS_THREE;  d.sel[ALU_SUB]  = 1'b1; end
      OP_AND:  begin d.cls = CLS_THREE;  d.sel[ALU_AND]  = 1'b1; end
      OP_OR:   begin d.cls = CLS_THREE;  d.sel[ALU_OR]   = 1'b1; end
      OP_ROR:  begin d.cls = CLS_THREE;  d.sel[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin d.cls = CLS_THREE;  d.sel[ALU_ROL]  = 1'b1; end
      OP_SHR:  begin d.cls = CLS_THREE;  d.sel[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin d.cls = CLS_THREE;  d.sel[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin d.cls = CLS_THREE;  d.sel[ALU_SHL]  = 1'b1; end
      OP_MUL:  begin d.cls = CLS_MULDIV; d.sel[ALU_MUL]  = 1'b1; end
      OP_DIV:  begin d.cls = CLS_MULDIV; d.sel[ALU_DIV]  = 1'b1; end
      OP_NEG:  begin d.cls = CLS_UNARY;  d.sel[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin d.cls = CLS_UNARY;  d.sel[ALU_NOT]  = 1'b1; end
      default: begin d.cls = CLS_ILLEGAL; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Handshake, instruction and datapath-control bundle between the sequencer
// (slave side) and whatever drives start/mem_ready/ir (master side).
interface alu_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
  logic        IncPC, Read;
  logic [12:0] alu_sel;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic [15:0] instr_count;

  modport master (
    output start, mem_ready, ir,
    input  Rin, Rout, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, IncPC, Read,
    input  alu_sel, busy, done, fault, fault_code, instr_count
  );

  modport slave (
    input  start, mem_ready, ir,
    output Rin, Rout, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, IncPC, Read,
    output alu_sel, busy, done, fault, fault_code, instr_count
  );
endinterface

// File: rtl/reg_decode.sv
// 4-bit register field to 16-bit one-hot select; all zeros when disabled.
module reg_decode (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer: walks T0..T6 for one instruction and
// Moore-decodes the datapath enables from the current state and the IR fields.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  alu_sequencer_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [15:0]        instr_count_q, instr_count_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  op_decode_t  dec;
  logic        unused_ir;

  logic        rin_en, rout_en;
  logic [3:0]  rin_field, rout_field;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];
  assign dec       = decode_op(opcode);
  assign wait_inc  = wait_q + WAIT_W'(1);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    fault_code_d  = fault_code_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_T0;
          fault_code_d = FC_NONE;
        end
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        if (bus.mem_ready) begin
          state_d = S_T2;
        end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
          state_d      = S_FAULT;
          fault_code_d = FC_MEM_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (dec.cls == CLS_ILLEGAL) begin
          state_d      = S_FAULT;
          fault_code_d = FC_ILLEGAL;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (dec.cls == CLS_MULDIV) ? S_T6 : S_DONE;
      S_T6: state_d = S_DONE;
      S_DONE: begin
        state_d       = S_IDLE;
        instr_count_d = instr_count_q + 16'd1;
        fault_code_d  = FC_NONE;
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      fault_code_q  <= FC_NONE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      fault_code_q  <= fault_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  // T3 onward reads the freshly loaded IR, so these stay combinational on state_q.
  always_comb begin
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.alu_sel  = '0;
    bus.done     = 1'b0;
    bus.fault    = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rin_field    = ra;
    rout_field   = rb;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (dec.cls != CLS_ILLEGAL) begin
          rout_en    = 1'b1;
          rout_field = (dec.cls == CLS_MULDIV) ? ra : rb;
          bus.Yin    = 1'b1;
        end
      end
      S_T4: begin
        rout_en     = 1'b1;
        rout_field  = (dec.cls == CLS_THREE) ? rc : rb;
        bus.alu_sel = dec.sel;
        bus.Zin     = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (dec.cls == CLS_MULDIV) bus.LOin = 1'b1;
        else                       rin_en   = 1'b1;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      S_DONE:  bus.done  = 1'b1;
      S_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy        = (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6});
  assign bus.fault_code  = fault_code_q;
  assign bus.instr_count = instr_count_q;

  reg_decode u_rin_dec (
    .field  (rin_field),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

  reg_decode u_rout_dec (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: each launch queues the expected per-cycle
// control trace; an independent monitor pops and compares whenever the DUT is active.
module tb_alu_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_count = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_sequencer_if bus();

  alu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [12:0] alu;
    logic [18:0] ctl;
    logic [1:0]  fcode;
    logic [15:0] icount;
  } ctl_t;

  typedef struct packed {
    ctl_t ctl;
    int   cyc;
  } exp_t;

  localparam logic [18:0] M_HIIN   = 19'h00001;
  localparam logic [18:0] M_LOIN   = 19'h00002;
  localparam logic [18:0] M_PCIN   = 19'h00004;
  localparam logic [18:0] M_IRIN   = 19'h00008;
  localparam logic [18:0] M_YIN    = 19'h00010;
  localparam logic [18:0] M_ZIN    = 19'h00020;
  localparam logic [18:0] M_MARIN  = 19'h00040;
  localparam logic [18:0] M_MDRIN  = 19'h00080;
  localparam logic [18:0] M_ZHIGH  = 19'h00400;
  localparam logic [18:0] M_ZLOW   = 19'h00800;
  localparam logic [18:0] M_PCOUT  = 19'h01000;
  localparam logic [18:0] M_MDROUT = 19'h02000;
  localparam logic [18:0] M_INCPC  = 19'h04000;
  localparam logic [18:0] M_READ   = 19'h08000;
  localparam logic [18:0] M_BUSY   = 19'h10000;
  localparam logic [18:0] M_DONE   = 19'h20000;
  localparam logic [18:0] M_FAULT  = 19'h40000;

  localparam int K_NORMAL  = 0;
  localparam int K_MULDIV  = 1;
  localparam int K_ILLEGAL = 2;
  localparam int K_TIMEOUT = 3;

  exp_t exp_q[$];
  ctl_t mon_act;
  exp_t mon_exp;

  function automatic ctl_t snap();
    ctl_t s;
    s.rin    = bus.Rin;
    s.rout   = bus.Rout;
    s.alu    = bus.alu_sel;
    s.ctl    = {bus.fault, bus.done, bus.busy, bus.Read, bus.IncPC, bus.MDRout,
                bus.PCout, bus.Zlowout, bus.Zhighout, bus.LOout, bus.HIout,
                bus.MDRin, bus.MARin, bus.Zin, bus.Yin, bus.IRin, bus.PCin,
                bus.LOin, bus.HIin};
    s.fcode  = bus.fault_code;
    s.icount = bus.instr_count;
    return s;
  endfunction

  function automatic exp_t mk(input int c, input logic [15:0] rin, input logic [15:0] rout,
                              input logic [12:0] alu, input logic [18:0] m, input logic [1:0] fc);
    exp_t e;
    e.cyc        = c;
    e.ctl.rin    = rin;
    e.ctl.rout   = rout;
    e.ctl.alu    = alu;
    e.ctl.ctl    = m;
    e.ctl.fcode  = fc;
    e.ctl.icount = 16'(model_count);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: one comparison per active DUT cycle against the queued trace.
  initial begin
    forever begin
      @(negedge clock);
      if (clear && (bus.busy || bus.done || bus.fault)) begin
        mon_act = snap();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ctl_unexpected: cycle %0d got %h, required no activity", cyc, mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp.ctl || cyc != mon_exp.cyc) begin
            n_fail++;
            $display("FAIL ctl_trace: cycle %0d got %h, required %h at cycle %0d",
                     cyc, mon_act, mon_exp.ctl, mon_exp.cyc);
          end
        end
      end
    end
  end

  task automatic launch(input logic [31:0] ir_v, input int kind, input int r3, input int r4,
                        input int r5, input int alu_bit, input int waits, input int abort_off,
                        input bit hold);
    exp_t tr[$];
    int   c, k, t1n;
    bit   finished, aborted;
    logic [12:0] alu1;
    finished = 1'b0;
    aborted  = 1'b0;
    alu1     = 13'd1 << alu_bit;
    @(posedge clock); #1;
    bus.ir        = ir_v;
    bus.start     = 1'b1;
    bus.mem_ready = 1'b0;
    c = cyc;
    k = c + 1;
    tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY, 2'b00));
    t1n = (kind == K_TIMEOUT) ? 15 : waits + 1;
    repeat (t1n) tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_BUSY, 2'b00));
    if (kind == K_TIMEOUT) begin
      tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_FAULT, 2'b01));
    end else begin
      tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_MDROUT | M_IRIN | M_BUSY, 2'b00));
      if (kind == K_ILLEGAL) begin
        tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_BUSY, 2'b00));
        tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_FAULT, 2'b10));
      end else begin
        tr.push_back(mk(k++, 16'h0, 16'd1 << r3, 13'h0, M_YIN | M_BUSY, 2'b00));
        tr.push_back(mk(k++, 16'h0, 16'd1 << r4, alu1, M_ZIN | M_BUSY, 2'b00));
        if (kind == K_MULDIV) begin
          tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_ZLOW | M_LOIN | M_BUSY, 2'b00));
          tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_ZHIGH | M_HIIN | M_BUSY, 2'b00));
        end else begin
          tr.push_back(mk(k++, 16'd1 << r5, 16'h0, 13'h0, M_ZLOW | M_BUSY, 2'b00));
        end
        tr.push_back(mk(k++, 16'h0, 16'h0, 13'h0, M_DONE, 2'b00));
        if (abort_off == 0) model_count = (model_count + 1) & 16'hFFFF;
      end
    end
    foreach (tr[i]) if (abort_off == 0 || tr[i].cyc < c + abort_off) exp_q.push_back(tr[i]);

    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if (!hold) bus.start = 1'b0;
      bus.mem_ready = (cyc >= c + 2 + waits) && (kind != K_TIMEOUT);
      if (abort_off != 0 && cyc == c + abort_off) begin
        chk("pre_clear_in_t4_zin", {127'd0, bus.Zin}, 128'd1);
        clear = 1'b0;
        #1;
        chk("clear_forces_idle", snap(), 128'd0);
        model_count = 0;
        #2;
        clear = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (bus.done || bus.fault) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished && !aborted) begin
      n_checks++;
      n_fail++;
      $display("FAIL seq_timeout: no done/fault within 60 cycles for ir %h, required one", ir_v);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir        = 32'h0;
    clear         = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    chk("reset_state", snap(), 128'd0);
    bus.start = 1'b0;
    clear     = 1'b1;

    // AND R2,R5,R6
    launch(32'h292B0000, K_NORMAL, 5, 6, 2, 2, 0, 0, 1'b0);
    // DIV R3,R1
    launch(32'h81880000, K_MULDIV, 3, 1, 0, 12, 0, 0, 1'b0);
    // ADD R1,R2,R3 with three not-ready cycles
    launch(32'h18918000, K_NORMAL, 2, 3, 1, 0, 3, 0, 1'b0);
    // memory never ready
    launch(32'h292B0000, K_TIMEOUT, 0, 0, 0, 0, 0, 0, 1'b0);
    @(posedge clock); #1;
    chk("fault_code_held_timeout", {126'd0, bus.fault_code}, 128'd1);
    chk("count_after_timeout", {112'd0, bus.instr_count}, 128'd3);
    // illegal opcode 00000
    launch(32'h00000000, K_ILLEGAL, 0, 0, 0, 0, 0, 0, 1'b0);
    @(posedge clock); #1;
    chk("fault_code_held_illegal", {126'd0, bus.fault_code}, 128'd2);
    chk("count_after_illegal", {112'd0, bus.instr_count}, 128'd3);
    // NEG R4,R7
    launch(32'h8A380000, K_NORMAL, 7, 7, 4, 9, 0, 0, 1'b0);
    // MUL R15,R14 with start held high into the next launch
    launch(32'h7FF00000, K_MULDIV, 15, 14, 0, 11, 0, 0, 1'b1);
    // SHRA R0,R9,R10
    launch(32'h504D0000, K_NORMAL, 9, 10, 0, 5, 0, 0, 1'b0);
    // ADD aborted by clear in T4, then a full ADD
    launch(32'h18918000, K_NORMAL, 2, 3, 1, 0, 0, 5, 1'b0);
    launch(32'h18918000, K_NORMAL, 2, 3, 1, 0, 0, 0, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    chk("final_instr_count", {112'd0, bus.instr_count}, 128'd1);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
